// File: rtl/instr_fetch_unit_pkg.sv
// Purpose : shared definitions for the fetch stage (state encoding, reset PC,
//           halt instruction word, default widths).
// Ports   : none (package).
package instr_fetch_unit_pkg;

  localparam int          IFU_PC_W       = 7;
  localparam int          IFU_INSTR_W    = 32;
  localparam logic [6:0]  IFU_RESET_PC   = 7'h00;
  localparam logic [31:0] IFU_HALT_INSTR = 32'hFFFF_FFFF;

  // DRAIN waits out a memory request that was in flight when a branch
  // redirect arrived, so the address bus never changes under a pending request.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_adder.sv
// Purpose : PC incrementer, o_sum = i_a + 1 modulo 2^W (wraps silently).
// Ports   : i_a  [W-1:0] in  - operand (current PC)
//           o_sum[W-1:0] out - i_a + 1
module adder #(
  parameter int W = 7
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_sum
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign o_sum = i_a + ONE;

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose : fetch stage. Owns the PC, drives instruction memory, loads IF/ID.
//           Handles hazard stall, EX branch redirect/flush, memory wait states, halt.
// Ports   : clk, rst_n (sync, active low); stall; branch_taken/branch_target;
//           imem_req/imem_addr out, imem_rdata/imem_ready in;
//           ifid_instr/ifid_pc_next/ifid_valid out; halted out.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                 PC_W       = IFU_PC_W,
  parameter int                 INSTR_W    = IFU_INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC   = IFU_RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_INSTR = IFU_HALT_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_next,
  output logic               ifid_valid,
  output logic               halted
);

  fetch_state_t        r_state;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_redir_tgt;
  logic [INSTR_W-1:0]  r_ifid_instr;
  logic [PC_W-1:0]     r_ifid_pc_next;
  logic                r_ifid_valid;
  logic [PC_W-1:0]     w_pc_inc;

  adder #(.W(PC_W)) u_adder (
    .i_a   (r_pc),
    .o_sum (w_pc_inc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_redir_tgt    <= '0;
      r_ifid_instr   <= '0;
      r_ifid_pc_next <= '0;
      r_ifid_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
        end

        ST_FETCH: begin
          if (branch_taken) begin
            // Flush wins over stall; the IF/ID slot becomes a bubble.
            r_ifid_valid <= 1'b0;
            if (imem_ready) begin
              r_pc <= branch_target;
            end else begin
              // Request still outstanding: keep address stable, remember target.
              r_redir_tgt <= branch_target;
              r_state     <= ST_DRAIN;
            end
          end else if (stall) begin
            // Hold everything; any response is dropped and re-fetched later.
          end else if (imem_ready) begin
            r_ifid_instr   <= imem_rdata;
            r_ifid_pc_next <= w_pc_inc;
            r_ifid_valid   <= 1'b1;
            if (imem_rdata == HALT_INSTR) begin
              r_state <= ST_HALTED;
            end else begin
              r_pc <= w_pc_inc;
            end
          end else begin
            r_ifid_valid <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (branch_taken) begin
            r_redir_tgt <= branch_target;
          end
          if (imem_ready) begin
            // A redirect arriving on the same cycle as the response is the newest.
            r_pc    <= branch_taken ? branch_target : r_redir_tgt;
            r_state <= ST_FETCH;
          end
        end

        ST_HALTED: begin
          if (!stall) begin
            r_ifid_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign halted       = (r_state == ST_HALTED);
  assign imem_addr    = r_pc;
  assign ifid_instr   = r_ifid_instr;
  assign ifid_pc_next = r_ifid_pc_next;
  assign ifid_valid   = r_ifid_valid;

endmodule
